// File: rtl/ram_arbiter_pkg.sv
// Shared constants, state encoding and port identifiers for the fetch/data RAM arbiter.
// These take the place of the shared config.v include macros.
package ram_arbiter_pkg;

  localparam int          XLEN           = 32;
  localparam int          IT_RAM_DEPTH   = 4096;
  localparam int          DATA_RAM_DEPTH = 4096;
  localparam logic        READ_ENABLE    = 1'b1;
  localparam logic        WRITE_ENABLE   = 1'b1;
  localparam logic [31:0] ZERO_32BIT     = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_RD = 2'd1,
    RESP_RD  = 2'd2,
    ISSUE_WR = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

endpackage

// File: rtl/ram_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single synchronous RAM.
// Data port has priority; a starvation counter guarantees the fetch port a grant.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int MEM_BYTES    = IT_RAM_DEPTH + DATA_RAM_DEPTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: a requester raises req with addr/we/wdata and holds all of them
  // stable until it sees a one-cycle ack or err; the arbiter samples them in IDLE only.
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [XLEN-1:0]   dm_wdata,
  output logic              dm_ack,
  output logic [XLEN-1:0]   dm_rdata,
  output logic              dm_err,
  output logic              ram_en,
  output logic              ram_read_flag,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [XLEN-1:0]   ram_read_data,
  output logic              ram_write_flag,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [XLEN-1:0]   ram_write_data,
  output arb_state_e        dbg_state
);

  localparam int                CNT_W          = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0]  STARVE_MAX     = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(MEM_BYTES - 4);

  arb_state_e        state_q, state_d;
  port_e             sel_q, sel_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              if_err_q, if_err_d;
  logic              dm_err_q, dm_err_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]   dm_rdata_q, dm_rdata_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_read_flag_q, ram_read_flag_d;
  logic              ram_write_flag_q, ram_write_flag_d;
  logic [ADDR_W-1:0] ram_read_addr_q, ram_read_addr_d;
  logic [ADDR_W-1:0] ram_write_addr_q, ram_write_addr_d;
  logic [XLEN-1:0]   ram_write_data_q, ram_write_data_d;

  logic              if_cand, dm_cand;
  logic              grant, grant_dm, grant_wr, grant_oor;
  logic [ADDR_W-1:0] grant_addr;

  // A port whose err is being pulsed this cycle still holds req; it is not a new request.
  always_comb begin
    if_cand    = if_req && !if_err_q;
    dm_cand    = dm_req && !dm_err_q;
    grant      = (state_q == IDLE) && (if_cand || dm_cand);
    grant_dm   = dm_cand && (!if_cand || (starve_q < STARVE_MAX));
    grant_addr = grant_dm ? dm_addr : if_addr;
    grant_wr   = grant_dm && dm_we;
    grant_oor  = grant_addr > LAST_WORD_ADDR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      sel_q            <= PORT_IF;
      starve_q         <= '0;
      if_err_q         <= 1'b0;
      dm_err_q         <= 1'b0;
      if_rdata_q       <= ZERO_32BIT;
      dm_rdata_q       <= ZERO_32BIT;
      ram_en_q         <= 1'b0;
      ram_read_flag_q  <= 1'b0;
      ram_write_flag_q <= 1'b0;
      ram_read_addr_q  <= '0;
      ram_write_addr_q <= '0;
      ram_write_data_q <= ZERO_32BIT;
    end else begin
      state_q          <= state_d;
      sel_q            <= sel_d;
      starve_q         <= starve_d;
      if_err_q         <= if_err_d;
      dm_err_q         <= dm_err_d;
      if_rdata_q       <= if_rdata_d;
      dm_rdata_q       <= dm_rdata_d;
      ram_en_q         <= ram_en_d;
      ram_read_flag_q  <= ram_read_flag_d;
      ram_write_flag_q <= ram_write_flag_d;
      ram_read_addr_q  <= ram_read_addr_d;
      ram_write_addr_q <= ram_write_addr_d;
      ram_write_data_q <= ram_write_data_d;
    end
  end

  // Out-of-range grants never leave IDLE; they only raise err next cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (grant && !grant_oor) begin
          sel_d   = grant_dm ? PORT_DM : PORT_IF;
          state_d = grant_wr ? ISSUE_WR : ISSUE_RD;
        end
      end
      ISSUE_RD: state_d = RESP_RD;
      RESP_RD:  state_d = IDLE;
      ISSUE_WR: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d         = starve_q;
    if_err_d         = 1'b0;
    dm_err_d         = 1'b0;
    if_rdata_d       = if_rdata_q;
    dm_rdata_d       = dm_rdata_q;
    ram_en_d         = 1'b0;
    ram_read_flag_d  = 1'b0;
    ram_write_flag_d = 1'b0;
    ram_read_addr_d  = ram_read_addr_q;
    ram_write_addr_d = ram_write_addr_q;
    ram_write_data_d = ram_write_data_q;

    if (state_q == RESP_RD) begin
      if (sel_q == PORT_IF) if_rdata_d = ram_read_data;
      else                  dm_rdata_d = ram_read_data;
    end

    if (grant) begin
      if (!grant_dm) begin
        starve_d = '0;
      end else if (if_cand && (starve_q < STARVE_MAX)) begin
        starve_d = starve_q + CNT_W'(1);
      end

      if (grant_oor) begin
        if (grant_dm) begin
          dm_err_d   = 1'b1;
          dm_rdata_d = ZERO_32BIT;
        end else begin
          if_err_d   = 1'b1;
          if_rdata_d = ZERO_32BIT;
        end
      end else if (grant_wr) begin
        ram_en_d         = 1'b1;
        ram_write_flag_d = WRITE_ENABLE;
        ram_write_addr_d = grant_addr;
        ram_write_data_d = dm_wdata;
      end else begin
        ram_en_d        = 1'b1;
        ram_read_flag_d = READ_ENABLE;
        ram_read_addr_d = grant_addr;
      end
    end
  end

  // Read data is forwarded from the RAM during the ack cycle and held afterwards.
  always_comb begin
    if_ack         = (state_q == RESP_RD) && (sel_q == PORT_IF);
    dm_ack         = ((state_q == RESP_RD) && (sel_q == PORT_DM)) || (state_q == ISSUE_WR);
    if_rdata       = ((state_q == RESP_RD) && (sel_q == PORT_IF)) ? ram_read_data : if_rdata_q;
    dm_rdata       = ((state_q == RESP_RD) && (sel_q == PORT_DM)) ? ram_read_data : dm_rdata_q;
    if_err         = if_err_q;
    dm_err         = dm_err_q;
    ram_en         = ram_en_q;
    ram_read_flag  = ram_read_flag_q;
    ram_read_addr  = ram_read_addr_q;
    ram_write_flag = ram_write_flag_q;
    ram_write_addr = ram_write_addr_q;
    ram_write_data = ram_write_data_q;
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level reference model (byte memory, starvation rule,
// per-transaction latencies) against a behavioural RAM attached to the RAM port.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int MB = 8192;
  localparam int SL = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req, if_ack, if_err;
  logic [AW-1:0]   if_addr;
  logic [31:0]     if_rdata;
  logic            dm_req, dm_we, dm_ack, dm_err;
  logic [AW-1:0]   dm_addr;
  logic [31:0]     dm_wdata, dm_rdata;
  logic            ram_en, ram_read_flag, ram_write_flag;
  logic [AW-1:0]   ram_read_addr, ram_write_addr;
  logic [31:0]     ram_read_data, ram_write_data;
  arb_state_e      dbg_state;

  ram_arbiter #(.ADDR_W(AW), .MEM_BYTES(MB), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .ram_en(ram_en), .ram_read_flag(ram_read_flag), .ram_read_addr(ram_read_addr),
    .ram_read_data(ram_read_data), .ram_write_flag(ram_write_flag),
    .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // environment RAM (one-cycle synchronous read) and the reference byte image
  logic [7:0] ram_mem [MB];
  logic [7:0] ref_mem [MB];
  always @(posedge clk) begin
    int ra, wa;
    ra = int'(ram_read_addr);
    wa = int'(ram_write_addr);
    if (ram_en && ram_read_flag && ra <= MB - 4)
      ram_read_data <= {ram_mem[ra+3], ram_mem[ra+2], ram_mem[ra+1], ram_mem[ra]};
    if (ram_en && ram_write_flag && wa <= MB - 4)
      for (int i = 0; i < 4; i++) ram_mem[wa+i] <= ram_write_data[8*i +: 8];
  end

  // scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;
  int ram_en_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("ack_exclusive", {63'd0, if_ack && dm_ack}, 64'd0);
      check("flag_exclusive", {63'd0, ram_read_flag && ram_write_flag}, 64'd0);
      check("en_matches_flag", {63'd0, ram_en}, {63'd0, ram_read_flag | ram_write_flag});
      if (ram_en) ram_en_cnt++;
    end
  end

  // reference model
  int          starve_m = 0;
  logic [31:0] last_if_rd = 32'h0;
  logic [31:0] last_dm_rd = 32'h0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int i;
    i = int'(a);
    return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) ref_mem[int'(a)+i] = d[8*i +: 8];
  endtask

  function automatic bit oor(input logic [31:0] a);
    return a > 32'(MB - 4);
  endfunction

  function automatic logic [31:0] rand_addr(input bit allow_oor);
    if (allow_oor && $urandom_range(0, 4) == 0) return 32'(MB - 3 + $urandom_range(0, 12));
    return 32'($urandom_range(0, MB - 4));
  endfunction

  // driver: one or two simultaneous requests issued while the arbiter is idle
  task automatic run_round(input bit use_if, input logic [31:0] ia, input bit use_dm,
                           input logic [31:0] da, input bit dwe, input logic [31:0] dwd);
    bit          if_oor, dm_oor, dm_first, if_done, dm_done;
    int          if_lat, dm_lat, if_busy, dm_busy, if_off, dm_off, exp_en, rel;
    int unsigned k0;
    logic [31:0] if_exp, dm_exp;
    if_oor  = oor(ia);
    dm_oor  = oor(da);
    if_lat  = if_oor ? 1 : 2;
    if_busy = if_oor ? 1 : 3;
    dm_lat  = (dm_oor || dwe) ? 1 : 2;
    dm_busy = dm_oor ? 1 : (dwe ? 2 : 3);
    dm_first = use_dm && (!use_if || starve_m < SL);
    if_off  = if_lat;
    dm_off  = dm_lat;
    if (use_if && use_dm) begin
      if (dm_first) if_off = dm_busy + if_lat;
      else          dm_off = if_busy + dm_lat;
    end
    exp_en = ((use_if && !if_oor) ? 1 : 0) + ((use_dm && !dm_oor) ? 1 : 0);
    if_exp = last_if_rd;
    dm_exp = last_dm_rd;
    for (int s = 0; s < 2; s++) begin
      if ((s == 0) == dm_first) begin
        if (use_dm) begin
          if (use_if && starve_m < SL) starve_m++;
          if (dm_oor)   dm_exp = 32'h0;
          else if (dwe) ref_wr(da, dwd);
          else          dm_exp = ref_rd(da);
        end
      end else if (use_if) begin
        starve_m = 0;
        if_exp = if_oor ? 32'h0 : ref_rd(ia);
      end
    end

    @(posedge clk); #1;
    if_req = use_if; if_addr = ia;
    dm_req = use_dm; dm_addr = da; dm_we = dwe; dm_wdata = dwd;
    k0 = cyc;
    ram_en_cnt = 0;
    if_done = !use_if;
    dm_done = !use_dm;
    for (int t = 0; t < 16 && !(if_done && dm_done); t++) begin
      @(negedge clk);
      rel = int'(cyc - k0);
      if (if_ack || if_err) begin
        if (if_done) check("if_spurious", {62'd0, if_ack, if_err}, 64'd0);
        else begin
          check("if_latency", 64'(rel), 64'(if_off));
          check("if_err_flag", {63'd0, if_err}, {63'd0, if_oor});
          check("if_rdata", {32'd0, if_rdata}, {32'd0, if_exp});
          if_done = 1'b1;
          last_if_rd = if_exp;
        end
      end
      if (dm_ack || dm_err) begin
        if (dm_done) check("dm_spurious", {62'd0, dm_ack, dm_err}, 64'd0);
        else begin
          check("dm_latency", 64'(rel), 64'(dm_off));
          check("dm_err_flag", {63'd0, dm_err}, {63'd0, dm_oor});
          check("dm_rdata", {32'd0, dm_rdata}, {32'd0, dm_exp});
          dm_done = 1'b1;
          last_dm_rd = dm_exp;
        end
      end
      if (ram_en && ram_read_flag)
        check("ram_read_addr", {32'd0, ram_read_addr},
              {32'd0, (use_if && !if_oor && rel == if_off - 1) ? ia : da});
      if (ram_en && ram_write_flag) begin
        check("ram_write_addr", {32'd0, ram_write_addr}, {32'd0, da});
        check("ram_write_data", {32'd0, ram_write_data}, {32'd0, dwd});
      end
      @(posedge clk); #1;
      if (if_done) if_req = 1'b0;
      if (dm_done) dm_req = 1'b0;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    check("round_complete", {62'd0, if_done, dm_done}, 64'd3);
    check("ram_en_cycles", 64'(ram_en_cnt), 64'(exp_en));
    @(negedge clk);
    check("quiet_after", {60'd0, if_ack, dm_ack, if_err, dm_err}, 64'd0);
    check("if_rdata_hold", {32'd0, if_rdata}, {32'd0, last_if_rd});
    check("dm_rdata_hold", {32'd0, dm_rdata}, {32'd0, last_dm_rd});
  endtask

  // both ports request without pause; order follows the starvation rule
  task automatic run_starve(input int n);
    int          got;
    bit          if_hit, dm_hit, exp_if;
    logic [31:0] ia, da, dwd;
    bit          dwe;
    ia = rand_addr(0); da = rand_addr(0); dwe = 1'(($urandom_range(0, 1))); dwd = $urandom;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = ia;
    dm_req = 1'b1; dm_addr = da; dm_we = dwe; dm_wdata = dwd;
    got = 0;
    for (int t = 0; t < 200 && got < n; t++) begin
      @(negedge clk);
      if_hit = if_ack || if_err;
      dm_hit = dm_ack || dm_err;
      if (if_hit || dm_hit) begin
        exp_if = (starve_m >= SL);
        check("grant_order", {62'd0, if_hit, dm_hit}, exp_if ? 64'd2 : 64'd1);
        if (exp_if) starve_m = 0;
        else        starve_m++;
        if (if_hit) begin
          last_if_rd = ref_rd(ia);
          check("starve_if_rdata", {32'd0, if_rdata}, {32'd0, last_if_rd});
        end
        if (dm_hit) begin
          if (dwe) ref_wr(da, dwd);
          else     last_dm_rd = ref_rd(da);
          check("starve_dm_rdata", {32'd0, dm_rdata}, {32'd0, last_dm_rd});
        end
        got++;
      end
      @(posedge clk); #1;
      if (got >= n) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end else begin
        if (if_hit) begin ia = rand_addr(0); if_addr = ia; end
        if (dm_hit) begin
          da = rand_addr(0); dwe = 1'($urandom_range(0, 1)); dwd = $urandom;
          dm_addr = da; dm_we = dwe; dm_wdata = dwd;
        end
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    check("starve_count", 64'(got), 64'(n));
    @(posedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_acks_errs"}, {60'd0, if_ack, dm_ack, if_err, dm_err}, 64'd0);
    check({tag, "_ram_ctrl"}, {61'd0, ram_en, ram_read_flag, ram_write_flag}, 64'd0);
    check({tag, "_ram_addr"}, {ram_read_addr, ram_write_addr}, 64'd0);
    check({tag, "_ram_wdata"}, {32'd0, ram_write_data}, 64'd0);
    check({tag, "_rdata"}, {if_rdata, dm_rdata}, 64'd0);
    check({tag, "_state"}, {62'd0, dbg_state}, {62'd0, IDLE});
  endtask

  // reset while a fetch sits in ISSUE_RD, then the held request is served again
  task automatic run_reset_abort();
    bit          saw_issue, acked;
    int unsigned k0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10;
    saw_issue = 1'b0;
    for (int t = 0; t < 6 && !saw_issue; t++) begin
      @(negedge clk);
      if (ram_en && ram_read_flag) saw_issue = 1'b1;
    end
    check("rst_reached_issue", {63'd0, saw_issue}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    starve_m = 0; last_if_rd = 32'h0; last_dm_rd = 32'h0;
    k0 = cyc;
    acked = 1'b0;
    for (int t = 0; t < 8 && !acked; t++) begin
      @(negedge clk);
      if (if_ack) begin
        acked = 1'b1;
        check("rst_reserve_latency", 64'(cyc - k0), 64'd2);
        last_if_rd = ref_rd(32'h10);
        check("rst_reserve_rdata", {32'd0, if_rdata}, {32'd0, last_if_rd});
      end
      @(posedge clk); #1;
      if (acked) if_req = 1'b0;
    end
    if_req = 1'b0;
    check("rst_reserved", {63'd0, acked}, 64'd1);
  endtask

  initial begin
    logic [7:0] b;
    bit use_if, use_dm;
    int kind;
    for (int i = 0; i < MB; i++) begin
      b = 8'($urandom);
      ram_mem[i] = b;
      ref_mem[i] = b;
    end
    ram_mem[16] = 8'h11; ram_mem[17] = 8'h22; ram_mem[18] = 8'h33; ram_mem[19] = 8'h44;
    ref_mem[16] = 8'h11; ref_mem[17] = 8'h22; ref_mem[18] = 8'h33; ref_mem[19] = 8'h44;
    ram_read_data = 32'h0;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_round(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0);
    run_round(1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'hDEADBEEF);
    run_round(1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 32'h0);
    run_round(1'b0, 32'h0, 1'b1, 32'(MB - 2), 1'b0, 32'h0);
    run_round(1'b1, 32'(MB - 3), 1'b1, 32'(MB - 4), 1'b0, 32'h0);
    run_round(1'b1, 32'h13, 1'b1, 32'h21, 1'b1, 32'hCAFEF00D);
    run_starve(10);
    run_reset_abort();

    for (int r = 0; r < 60; r++) begin
      kind = $urandom_range(0, 2);
      use_if = (kind != 1);
      use_dm = (kind != 0);
      run_round(use_if, rand_addr(1), use_dm, rand_addr(1), 1'($urandom_range(0, 1)), $urandom);
    end
    run_starve(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, the byte-address width of both requester ports and the RAM port.
REQ-002 The module SHALL have parameter MEM_BYTES, default `IT_RAM_DEPTH + `DATA_RAM_DEPTH, the RAM size in bytes.
REQ-003 The module SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive data-port grants while a fetch is pending.
REQ-004 The module SHALL have one clock, clk (input, 1 bit, rising-edge), and one synchronous active-high reset, rst (input, 1 bit).
REQ-005 The fetch port SHALL be: if_req in 1, read request; if_addr in ADDR_W, byte address; if_ack out 1, one-cycle completion pulse; if_rdata out `XLEN, read word; if_err out 1, out-of-range pulse.
REQ-006 The data port SHALL be: dm_req in 1, request; dm_we in 1, 1 = write; dm_addr in ADDR_W, byte address; dm_wdata in `XLEN, write word; dm_ack out 1; dm_rdata out `XLEN; dm_err out 1.
REQ-007 The RAM port SHALL be: ram_en out 1; ram_read_flag out 1; ram_read_addr out ADDR_W; ram_read_data in `XLEN; ram_write_flag out 1; ram_write_addr out ADDR_W; ram_write_data out `XLEN.

Function
REQ-008 The FSM SHALL have four states: IDLE, ISSUE_RD, RESP_RD, ISSUE_WR.
REQ-009 A requester SHALL hold req, addr, we and wdata stable from assertion until its ack or err; the arbiter SHALL sample these fields only in IDLE.
REQ-010 In IDLE, when only one req is high, that port SHALL be granted; when both are high, dm SHALL win unless starve_cnt >= STARVE_LIMIT, in which case if SHALL win.
REQ-011 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each dm grant made while if_req is high, and SHALL clear on every if grant.
REQ-012 A granted read SHALL move IDLE -> ISSUE_RD (registered ram_en=1, ram_read_flag=`READ_ENABLE, ram_read_addr=latched addr) -> RESP_RD -> IDLE.
REQ-013 In RESP_RD, the granted port SHALL pulse ack for exactly one cycle, and its rdata SHALL equal ram_read_data, little-endian as delivered by the RAM; read latency SHALL be 2 cycles from the grant cycle.
REQ-014 A granted dm write SHALL move IDLE -> ISSUE_WR -> IDLE; ISSUE_WR SHALL drive ram_en=1, ram_write_flag=`WRITE_ENABLE and the latched addr/wdata, and SHALL pulse dm_ack in the same cycle.
REQ-015 ram_read_flag and ram_write_flag SHALL never be asserted in the same cycle; ram_en SHALL be 0 in IDLE and RESP_RD.
REQ-016 A request with addr > MEM_BYTES-4 SHALL generate no RAM access; the arbiter SHALL go IDLE -> IDLE, pulse err the following cycle and drive rdata = `ZERO_32BIT, with no ack.
REQ-017 Unaligned in-range addresses SHALL be passed to the RAM unchanged.
REQ-018 rdata on each port SHALL hold its last value between acks; if_ack and dm_ack SHALL never both be high in the same cycle.
REQ-019 A new grant SHALL be possible only in IDLE, giving back-to-back throughput of one read per 3 cycles and one write per 2 cycles.

Reset
REQ-020 On rst: state=IDLE; starve_cnt=0; all ack, err and RAM flag outputs = 0; RAM address outputs = 0; rdata and ram_write_data = `ZERO_32BIT.
REQ-021 Reset mid-transaction SHALL abort it with no ack; the held request SHALL be re-arbitrated after reset deasserts.

Structure
REQ-022 `XLEN, `READ_ENABLE, `WRITE_ENABLE, `ZERO_32BIT, the RAM depth macros and the FSM state encodings SHALL come from the shared config.v include.
REQ-023 The block SHALL be a single module; its natural companion is ram, instantiated by the parent, not inside ram_arbiter.

Verification
REQ-024 Bench: if read addr 0x10 (RAM holds 0x44332211 there) -> if_ack 2 cycles after grant, if_rdata=0x44332211.
REQ-025 Bench: dm write 0x20 = 0xDEADBEEF, then dm read 0x20 -> dm_ack in ISSUE_WR, then dm_rdata=0xDEADBEEF.
REQ-026 Bench: both ports requesting continuously with STARVE_LIMIT=4 -> grant order dm,dm,dm,dm,if,dm...
REQ-027 Bench: dm read at MEM_BYTES-2 -> no ram_en, dm_err pulse, dm_rdata=0.
REQ-028 Bench: rst asserted in ISSUE_RD -> no if_ack, outputs at reset values, and the request is re-served after reset.
